// File: rtl/irq_controller.sv
// Prioritised edge-triggered interrupt controller with a
// request/ack/done handshake toward the core; no nesting.
module irq_controller #(
  parameter int          NUM_SRC  = 8,
  parameter int          ID_W     = 3,
  parameter logic [31:0] VEC_BASE = 32'h0000_0100
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  input  logic               int_ack,
  input  logic               int_done,
  output logic               interrupt,
  output logic [31:0]        vector,
  output logic [ID_W-1:0]    irq_id,
  output logic               in_service,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] mask
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] SERVICE = 2'd2;

  logic [1:0]         r_state;
  logic [NUM_SRC-1:0] r_prev;
  logic [NUM_SRC-1:0] w_rise;
  logic [NUM_SRC-1:0] w_elig;
  logic [NUM_SRC-1:0] w_clr;
  logic [ID_W-1:0]    w_win;
  logic               w_ack;
  logic               w_done;

  assign w_rise = irq_src & ~r_prev;
  assign w_elig = pending & mask;
  assign w_ack  = (r_state == REQ) && int_ack;
  assign w_done = (r_state == SERVICE) && int_done;
  assign w_clr  = w_ack ? (NUM_SRC'(1) << irq_id) : '0;

  // Scan downward so the lowest eligible index is the last to win.
  always_comb begin
    w_win = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_elig[i]) w_win = ID_W'(i);
    end
  end

  assign interrupt  = (r_state == REQ);
  assign in_service = (r_state == SERVICE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev  <= '0;
      r_state <= IDLE;
      pending <= '0;
      mask    <= '0;
      vector  <= '0;
      irq_id  <= '0;
    end else begin
      r_prev  <= irq_src;
      // A fresh edge on the acknowledged source survives the clear.
      pending <= (pending & ~w_clr) | w_rise;
      if (mask_we) mask <= mask_wdata;
      unique case (1'b1)
        (r_state == IDLE): begin
          if (w_elig != '0) begin
            r_state <= REQ;
            irq_id  <= w_win;
            vector  <= VEC_BASE + (32'(w_win) << 2);
          end
        end
        (r_state == REQ): begin
          if (w_ack) r_state <= SERVICE;
        end
        (r_state == SERVICE): begin
          if (w_done) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: handshake, priority,
// masking, freeze, set/clear collision and async reset.
module tb_irq_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  irq_src = '0;
  logic        mask_we = 1'b0;
  logic [7:0]  mask_wdata = '0;
  logic        int_ack = 1'b0;
  logic        int_done = 1'b0;
  logic        interrupt;
  logic [31:0] vector;
  logic [2:0]  irq_id;
  logic        in_service;
  logic [7:0]  pending;
  logic [7:0]  mask;

  int vecs = 0;
  int errs = 0;

  irq_controller #(
    .NUM_SRC(8), .ID_W(3), .VEC_BASE(32'h0000_0100)
  ) dut (
    .clk(clk), .reset(reset), .irq_src(irq_src),
    .mask_we(mask_we), .mask_wdata(mask_wdata),
    .int_ack(int_ack), .int_done(int_done),
    .interrupt(interrupt), .vector(vector), .irq_id(irq_id),
    .in_service(in_service), .pending(pending), .mask(mask)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_mask(input logic [7:0] m);
    mask_we = 1'b1; mask_wdata = m;
    step();
    mask_we = 1'b0;
  endtask

  task automatic ack_done();
    int_ack = 1'b1; step(); int_ack = 1'b0;
    int_done = 1'b1; step(); int_done = 1'b0;
  endtask

  task automatic test_reset();
    #3 reset = 1'b1;
    step();
    vecs++;
    if ({interrupt, in_service, irq_id, vector, pending, mask} !== 52'd0) begin
      errs++;
      $display("FAIL reset_state got int=%0b svc=%0b id=%0d vec=%h pend=%h mask=%h exp all 0",
               interrupt, in_service, irq_id, vector, pending, mask);
    end
  endtask

  task automatic test_single();
    write_mask(8'hFF);
    vecs++;
    if (mask !== 8'hFF) begin
      errs++; $display("FAIL mask_write got %h exp ff", mask);
    end
    irq_src = 8'h08; step(); irq_src = 8'h00;
    vecs++;
    if (pending !== 8'h08 || interrupt !== 1'b0) begin
      errs++; $display("FAIL single_pend got pend=%h int=%0b exp 08/0", pending, interrupt);
    end
    step();
    vecs++;
    if (interrupt !== 1'b1 || irq_id !== 3'd3 || vector !== 32'h0000_010C) begin
      errs++;
      $display("FAIL single_req got int=%0b id=%0d vec=%h exp 1/3/0000010c", interrupt, irq_id, vector);
    end
    int_ack = 1'b1; step(); int_ack = 1'b0;
    vecs++;
    if (pending !== 8'h00 || in_service !== 1'b1 || interrupt !== 1'b0) begin
      errs++;
      $display("FAIL single_ack got pend=%h svc=%0b int=%0b exp 00/1/0", pending, in_service, interrupt);
    end
    int_done = 1'b1; step(); int_done = 1'b0;
    vecs++;
    if (in_service !== 1'b0 || interrupt !== 1'b0 || irq_id !== 3'd3) begin
      errs++;
      $display("FAIL single_done got svc=%0b int=%0b id=%0d exp 0/0/3", in_service, interrupt, irq_id);
    end
  endtask

  task automatic test_priority();
    irq_src = 8'h24; step(); irq_src = 8'h00;
    step();
    vecs++;
    if (interrupt !== 1'b1 || irq_id !== 3'd2 || vector !== 32'h0000_0108) begin
      errs++;
      $display("FAIL prio_first got int=%0b id=%0d vec=%h exp 1/2/00000108", interrupt, irq_id, vector);
    end
    ack_done();
    vecs++;
    if (interrupt !== 1'b0 || pending !== 8'h20) begin
      errs++; $display("FAIL prio_gap got int=%0b pend=%h exp 0/20", interrupt, pending);
    end
    step();
    vecs++;
    if (interrupt !== 1'b1 || irq_id !== 3'd5 || vector !== 32'h0000_0114) begin
      errs++;
      $display("FAIL prio_second got int=%0b id=%0d vec=%h exp 1/5/00000114", interrupt, irq_id, vector);
    end
    ack_done();
  endtask

  task automatic test_masking();
    write_mask(8'hFE);
    irq_src = 8'h01; step(); irq_src = 8'h00;
    step();
    vecs++;
    if (pending !== 8'h01 || interrupt !== 1'b0) begin
      errs++; $display("FAIL mask_block got pend=%h int=%0b exp 01/0", pending, interrupt);
    end
    write_mask(8'h01);
    vecs++;
    if (interrupt !== 1'b0) begin
      errs++; $display("FAIL mask_early got int=%0b exp 0", interrupt);
    end
    step();
    vecs++;
    if (interrupt !== 1'b1 || irq_id !== 3'd0 || vector !== 32'h0000_0100) begin
      errs++;
      $display("FAIL mask_req got int=%0b id=%0d vec=%h exp 1/0/00000100", interrupt, irq_id, vector);
    end
    ack_done();
    write_mask(8'hFF);
  endtask

  task automatic test_freeze();
    irq_src = 8'h10; step(); irq_src = 8'h00;
    step();
    irq_src = 8'h02; step(); irq_src = 8'h00;
    vecs++;
    if (interrupt !== 1'b1 || irq_id !== 3'd4 || vector !== 32'h0000_0110 || pending !== 8'h12) begin
      errs++;
      $display("FAIL freeze_req got int=%0b id=%0d vec=%h pend=%h exp 1/4/00000110/12",
               interrupt, irq_id, vector, pending);
    end
    int_done = 1'b1; step(); int_done = 1'b0;
    vecs++;
    if (interrupt !== 1'b1 || in_service !== 1'b0) begin
      errs++; $display("FAIL done_in_req got int=%0b svc=%0b exp 1/0", interrupt, in_service);
    end
    int_ack = 1'b1; step(); int_ack = 1'b0;
    step();
    vecs++;
    if (interrupt !== 1'b0 || in_service !== 1'b1 || pending !== 8'h02) begin
      errs++;
      $display("FAIL no_nest got int=%0b svc=%0b pend=%h exp 0/1/02", interrupt, in_service, pending);
    end
    int_done = 1'b1; step(); int_done = 1'b0;
    step();
    vecs++;
    if (interrupt !== 1'b1 || irq_id !== 3'd1 || vector !== 32'h0000_0104) begin
      errs++;
      $display("FAIL freeze_next got int=%0b id=%0d vec=%h exp 1/1/00000104", interrupt, irq_id, vector);
    end
    ack_done();
  endtask

  task automatic test_collision();
    irq_src = 8'h40; step(); irq_src = 8'h00;
    step();
    vecs++;
    if (interrupt !== 1'b1 || irq_id !== 3'd6) begin
      errs++; $display("FAIL coll_req got int=%0b id=%0d exp 1/6", interrupt, irq_id);
    end
    int_ack = 1'b1; irq_src = 8'h40; step();
    int_ack = 1'b0; irq_src = 8'h00;
    vecs++;
    if (pending !== 8'h40 || in_service !== 1'b1) begin
      errs++; $display("FAIL coll_pend got pend=%h svc=%0b exp 40/1", pending, in_service);
    end
    int_done = 1'b1; step(); int_done = 1'b0;
    step();
    vecs++;
    if (interrupt !== 1'b1 || irq_id !== 3'd6 || vector !== 32'h0000_0118) begin
      errs++;
      $display("FAIL coll_rereq got int=%0b id=%0d vec=%h exp 1/6/00000118", interrupt, irq_id, vector);
    end
    ack_done();
  endtask

  task automatic test_async_reset();
    irq_src = 8'h08; step(); irq_src = 8'h00;
    step();
    int_ack = 1'b1; step(); int_ack = 1'b0;
    #2 reset = 1'b0;
    #1;
    vecs++;
    if ({interrupt, in_service, irq_id, vector, pending, mask} !== 52'd0) begin
      errs++;
      $display("FAIL async_reset got int=%0b svc=%0b id=%0d vec=%h pend=%h mask=%h exp all 0",
               interrupt, in_service, irq_id, vector, pending, mask);
    end
    #3 reset = 1'b1;
    write_mask(8'hFF);
    step(); step();
    vecs++;
    if (interrupt !== 1'b0 || pending !== 8'h00) begin
      errs++; $display("FAIL quiet_release got int=%0b pend=%h exp 0/00", interrupt, pending);
    end
    #2 reset = 1'b0;
    irq_src = 8'h04;
    #4 reset = 1'b1;
    step();
    vecs++;
    if (pending !== 8'h04 || interrupt !== 1'b0) begin
      errs++; $display("FAIL level_release got pend=%h int=%0b exp 04/0", pending, interrupt);
    end
    step();
    vecs++;
    if (pending !== 8'h04 || interrupt !== 1'b0) begin
      errs++; $display("FAIL level_masked got pend=%h int=%0b exp 04/0", pending, interrupt);
    end
    irq_src = 8'h00;
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_masking();
    test_freeze();
    test_collision();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Prioritised interrupt controller directly upstream of the processor's main control unit.
- Drives the `interrupt` request and a 32-bit handler vector from up to NUM_SRC edge-triggered peripheral sources.
- Runs a request/acknowledge/return handshake with the core; no nesting.
- Keeps per-source pending and enable state.

Parameters:
- NUM_SRC, 8: number of interrupt sources (2..16).
- ID_W, 3: width of source index; must equal ceil(log2(NUM_SRC)).
- VEC_BASE, 32'h0000_0100: base byte address of the vector table.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- irq_src  in  NUM_SRC  source request lines, synchronous to clk, rising-edge sensitive.
- mask_we  in  1  write strobe for the enable register.
- mask_wdata  in  NUM_SRC  new enable value (1 = enabled).
- int_ack  in  1  core accepts the current request (pulse).
- int_done  in  1  core finished the handler, return-from-interrupt (pulse).
- interrupt  out  1  request to the control unit.
- vector  out  32  handler address for the granted source.
- irq_id  out  ID_W  index of the granted source.
- in_service  out  1  handler in progress.
- pending  out  NUM_SRC  pending register.
- mask  out  NUM_SRC  enable register.

Behaviour:
- Reset (reset=0, asynchronous):
  - Internal registers: prev_src=0, FSM=IDLE.
  - Outputs: pending=0, mask=0 (all disabled), interrupt=0, vector=0, irq_id=0, in_service=0.
- Edge detect:
  - rise[i] = irq_src[i] & ~prev_src[i]; prev_src <= irq_src every cycle.
  - Level held high produces one event only.
- Pending:
  - At the edge where rise[i]=1, pending[i] <= 1.
  - pending[id] is cleared at the edge where int_ack is accepted in REQ.
  - Same-cycle set and clear of the same bit: set wins, bit stays 1.
- Mask:
  - mask_we=1 -> mask <= mask_wdata at the next edge.
  - Masked sources still latch pending; they are only excluded from selection.
- Selection: eligible = pending & mask; the lowest index wins (bit 0 highest priority).
- FSM states IDLE, REQ, SERVICE:
  - IDLE: if eligible != 0, go to REQ at the next edge and latch irq_id = winner and vector = VEC_BASE + (winner << 2), 32-bit modulo 2^32.
  - REQ: interrupt=1; irq_id and vector frozen even if a higher-priority source arrives or the source is masked. int_ack=1 -> SERVICE at the next edge, interrupt=0 from then on.
  - SERVICE: in_service=1, interrupt=0; new events only set pending. int_done=1 -> IDLE at the next edge. If eligible != 0 in IDLE, the next REQ follows one cycle later (no zero-gap back-to-back).
- Outputs are registered. irq_id and vector keep their last value outside REQ/SERVICE.
- Ignored inputs:
  - int_ack outside REQ.
  - int_done outside SERVICE.
  - int_ack and int_done asserted together: only the one valid in the current state acts.
- Latency: irq_src rises before edge k -> pending set at k -> REQ (interrupt=1) after edge k+1, provided the source is enabled and the FSM is IDLE.
- Reset asserted mid-operation (REQ/SERVICE) drops to IDLE immediately with all state cleared. Sources held high through reset release do not generate an event, because prev_src=0 and rise is computed only after release. Correction: prev_src resets to 0, so a level high at release DOES generate one event at the first edge; the bench must check this.

Test Plan:
- Single source: mask=8'hFF, pulse irq_src[3] -> pending=8'h08 at edge k, interrupt=1 after k+1, irq_id=3, vector=32'h0000_010C; int_ack -> pending=0, in_service=1; int_done -> IDLE, in_service=0.
- Priority: raise irq_src[5] and irq_src[2] in the same cycle -> irq_id=2, vector=32'h0000_0108; after ack/done, second request irq_id=5, vector=32'h0000_0114.
- Masking: mask=8'hFE, pulse irq_src[0] -> pending[0]=1, interrupt stays 0; write mask=8'h01 -> interrupt=1 two cycles later, irq_id=0.
- Freeze and no nesting: in REQ for id 4, pulse irq_src[1] -> irq_id stays 4; ack, then in SERVICE interrupt stays 0 with pending[1]=1; int_done -> REQ with irq_id=1.
- Set/clear collision: irq_src[6] gets a new rising edge in the same cycle as int_ack for id 6 -> pending[6] stays 1 and is re-requested after int_done.
- Async reset: assert reset low mid-SERVICE between clock edges -> all outputs 0 immediately; release with irq_src=0 -> no request.
